// File: rtl/mips_pkg.sv
// Shared MIPS core constants and types.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register busy bits plus a running busy count.
// Latency: state updates on the rising edge; no backpressure, accepts every cycle.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              clr0_en,
  input  logic [AW-1:0]     clr0_addr,
  input  logic              clr1_en,
  input  logic [AW-1:0]     clr1_addr,
  output logic [2**AW-1:0]  busy,
  output logic [AW:0]       busy_cnt
);
  logic [2**AW-1:0] busy_nxt;
  logic             inc;
  logic             dec0;
  logic             dec1;
  logic [AW:0]      cnt_nxt;

  // Clears first, then alloc, so alloc wins on a same-register collision.
  always_comb begin
    busy_nxt = busy;
    if (clr0_en) busy_nxt[clr0_addr] = 1'b0;
    if (clr1_en) busy_nxt[clr1_addr] = 1'b0;
    if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
  end

  // Each count step tracks a real 0->1 or 1->0 transition of a distinct bit.
  always_comb begin
    inc  = alloc_en && !busy[alloc_addr];
    dec0 = clr0_en && busy[clr0_addr] && !busy_nxt[clr0_addr];
    dec1 = clr1_en && busy[clr1_addr] && !busy_nxt[clr1_addr] &&
           !(clr0_en && (clr0_addr == clr1_addr));
    cnt_nxt = busy_cnt + (AW+1)'(inc) - (AW+1)'(dec0) - (AW+1)'(dec1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/pipelined_reg_file.sv
// Two-read/two-write register file with RAW scoreboard, optional bypass and zero register.
// Latency: reads combinational, writes on the rising edge; no backpressure.
module pipelined_reg_file #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              rbusy0,
  output logic              rbusy1,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic              w0;
  logic              w1;
  logic              aen;

  // Register 0 swallows writes and allocs when hardwired to zero.
  always_comb begin
    w0  = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    w1  = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    aen = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (w0) regs[wa0] <= wd0;
      if (w1) regs[wa1] <= wd1;
    end
  end

  reg_scoreboard #(.AW(ADDR_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (aen),
    .alloc_addr (alloc_addr),
    .clr0_en    (w0),
    .clr0_addr  (wa0),
    .clr1_en    (w1),
    .clr1_addr  (wa1),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

  // Port 1 is checked first so the load unit wins a same-address bypass.
  always_comb begin
    rd0    = regs[ra0];
    rd1    = regs[ra1];
    rbusy0 = busy[ra0];
    rbusy1 = busy[ra1];
    if (BYPASS != 0) begin
      if (w1 && (wa1 == ra0)) rd0 = wd1;
      else if (w0 && (wa0 == ra0)) rd0 = wd0;
      if (w1 && (wa1 == ra1)) rd1 = wd1;
      else if (w0 && (wa0 == ra1)) rd1 = wd0;
      if ((w0 && (wa0 == ra0)) || (w1 && (wa1 == ra0))) rbusy0 = 1'b0;
      if ((w0 && (wa0 == ra1)) || (w1 && (wa1 == ra1))) rbusy1 = 1'b0;
    end
    if ((ZERO_REG != 0) && (ra0 == '0)) begin
      rd0    = '0;
      rbusy0 = 1'b0;
    end
    if ((ZERO_REG != 0) && (ra1 == '0)) begin
      rd1    = '0;
      rbusy1 = 1'b0;
    end
    // Bypass must not leak write data while the file is held in reset.
    if (!rst) begin
      rd0    = '0;
      rd1    = '0;
      rbusy0 = 1'b0;
      rbusy1 = 1'b0;
    end
  end
endmodule

// File: tb/tb_pipelined_reg_file.sv
// Randomised scoreboard bench for pipelined_reg_file against an array/queue reference model.
module tb_pipelined_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  typedef struct packed {
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic          rb0;
    logic          rb1;
    logic [AW:0]   cnt;
  } obs_t;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ra0, ra1, wa0, wa1, alloc_addr;
  logic [DW-1:0] wd0, wd1, rd0, rd1;
  logic          we0, we1, alloc_en, rbusy0, rbusy1;
  logic [AW:0]   busy_cnt;

  pipelined_reg_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .rbusy0(rbusy0), .rbusy1(rbusy1), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .busy_cnt(busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  obs_t          expq [$];
  int            n_vec = 0;
  int            n_bad = 0;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (!rst || a == 0) return '0;
    v = m_regs[a];
    if (we0 && wa0 == a) v = wd0;
    if (we1 && wa1 == a) v = wd1;
    return v;
  endfunction

  function automatic logic m_rbusy(input logic [AW-1:0] a);
    if (!rst || a == 0) return 1'b0;
    if ((we0 && wa0 == a) || (we1 && wa1 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [AW:0] m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) c++;
    return (AW+1)'(c);
  endfunction

  // Push expectation for the current cycle, then advance the model across the edge.
  task automatic issue();
    obs_t e;
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end
    e.rd0 = m_read(ra0);
    e.rd1 = m_read(ra1);
    e.rb0 = m_rbusy(ra0);
    e.rb1 = m_rbusy(ra1);
    e.cnt = rst ? m_count() : '0;
    expq.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (we0 && wa0 != 0) begin m_regs[wa0] = wd0; m_busy[wa0] = 1'b0; end
      if (we1 && wa1 != 0) begin m_regs[wa1] = wd1; m_busy[wa1] = 1'b0; end
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; alloc_en = 0;
    wa0 = 0; wa1 = 0; alloc_addr = 0; wd0 = 0; wd1 = 0;
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = '{rd0: rd0, rd1: rd1, rb0: rbusy0, rb1: rbusy1, cnt: busy_cnt};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got rd0=%h rd1=%h rbusy=%b%b cnt=%0d, want rd0=%h rd1=%h rbusy=%b%b cnt=%0d",
                 n_vec, a.rd0, a.rd1, a.rb0, a.rb1, a.cnt, e.rd0, e.rd1, e.rb0, e.rb1, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    ra0 = 0; ra1 = 0;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state on every address, with junk stimulus that must be discarded.
    for (int i = 0; i < NR; i++) begin
      ra0 = AW'(i); ra1 = AW'(NR-1-i);
      we0 = 1; wa0 = AW'(i); wd0 = $urandom; alloc_en = 1; alloc_addr = AW'(i);
      issue();
    end
    idle();
    rst = 1'b1;
    for (int i = 0; i < NR; i += 4) begin
      ra0 = AW'(i); ra1 = AW'(i+1);
      issue();
    end

    // Same-cycle bypass then stored value.
    we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; ra0 = 3; ra1 = 4;
    issue();
    idle(); issue();

    // Both ports to one address: port 1 wins.
    we0 = 1; wa0 = 7; wd0 = 1; we1 = 1; wa1 = 7; wd1 = 2; ra0 = 7; ra1 = 7;
    issue();
    idle(); issue();

    // Scoreboard: alloc/alloc, alloc+write same reg, dual clear.
    ra0 = 5; ra1 = 9;
    alloc_en = 1; alloc_addr = 5; issue();
    alloc_addr = 9; issue();
    idle(); issue();
    we0 = 1; wa0 = 5; wd0 = 32'h55; alloc_en = 1; alloc_addr = 5; issue();
    idle(); issue();
    we0 = 1; wa0 = 5; wd0 = 32'h66; we1 = 1; wa1 = 9; wd1 = 32'h99; issue();
    idle(); issue();

    // Zero register ignores write and alloc.
    ra0 = 0; ra1 = 0;
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; alloc_en = 1; alloc_addr = 0; issue();
    idle(); issue();

    // Mid-cycle reset with four pending registers.
    for (int i = 1; i <= 4; i++) begin
      alloc_en = 1; alloc_addr = AW'(i * 2); we0 = 1; wa0 = AW'(i * 2 + 1); wd0 = $urandom;
      ra0 = AW'(i * 2); ra1 = AW'(i * 2 - 1);
      issue();
    end
    idle(); ra0 = 2; ra1 = 3;
    #1 rst = 1'b0;
    we1 = 1; wa1 = 2; wd1 = 32'h1234; issue();
    idle();
    rst = 1'b1;
    issue();

    // Random traffic, half the cycles squeezed onto 8 registers to force collisions.
    for (int n = 0; n < 600; n++) begin
      int hi = ($urandom_range(0, 1) == 1) ? 7 : NR - 1;
      ra0 = AW'($urandom_range(0, hi)); ra1 = AW'($urandom_range(0, hi));
      we0 = 1'($urandom); wa0 = AW'($urandom_range(0, hi)); wd0 = $urandom;
      we1 = 1'($urandom); wa1 = AW'($urandom_range(0, hi)); wd1 = $urandom;
      alloc_en = 1'($urandom); alloc_addr = AW'($urandom_range(0, hi));
      if (n == 300) begin
        #1 rst = 1'b0;
        issue();
        rst = 1'b1;
      end else begin
        issue();
      end
    end
    idle();
    issue();
    @(negedge clk); #1;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
